// File: rtl/cricket_pkg.sv
// Shared types and constants for the T20 scoring datapath.
// Holds the delivery event codes, the innings state encoding and the extras ceiling.
package cricket_pkg;

    typedef enum logic [1:0] {
        EV_LEGAL  = 2'd0,
        EV_WIDE   = 2'd1,
        EV_NOBALL = 2'd2,
        EV_WICKET = 2'd3
    } ev_code_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INN1  = 3'd1,
        S_BREAK = 3'd2,
        S_INN2  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [7:0] EXTRAS_MAX = 8'd255;

endpackage

// File: rtl/innings_counter.sv
// Per-innings counters: legal balls, completed overs, balls in the current over,
// wickets and saturating extras. clr restarts the counters for a new innings.
module innings_counter
    import cricket_pkg::*;
#(
    parameter int OVERS          = 20,
    parameter int BALLS_PER_OVER = 6,
    parameter int BALL_W         = $clog2(OVERS * BALLS_PER_OVER + 1),
    parameter int OVER_W         = $clog2(OVERS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc_ball,
    input  logic              inc_wkt,
    input  logic              inc_extra,
    output logic [BALL_W-1:0] ball,
    output logic [OVER_W-1:0] over_count,
    output logic [3:0]        ball_in_over,
    output logic [3:0]        wickets,
    output logic [7:0]        extras
);

    localparam logic [3:0] BIO_LAST = 4'(BALLS_PER_OVER - 1);

    logic [BALL_W-1:0] ball_q, ball_d;
    logic [OVER_W-1:0] over_q, over_d;
    logic [3:0]        bio_q, bio_d;
    logic [3:0]        wkt_q, wkt_d;
    logic [7:0]        extras_q, extras_d;

    always_comb begin
        ball_d   = ball_q;
        over_d   = over_q;
        bio_d    = bio_q;
        wkt_d    = wkt_q;
        extras_d = extras_q;
        if (clr) begin
            ball_d   = '0;
            over_d   = '0;
            bio_d    = '0;
            wkt_d    = '0;
            extras_d = '0;
        end else begin
            if (inc_ball) begin
                ball_d = ball_q + BALL_W'(1);
                // Completing the over rolls balls-in-over back to zero.
                if (bio_q == BIO_LAST) begin
                    bio_d  = '0;
                    over_d = over_q + OVER_W'(1);
                end else begin
                    bio_d = bio_q + 4'd1;
                end
            end
            if (inc_wkt) begin
                wkt_d = wkt_q + 4'd1;
            end
            if (inc_extra && (extras_q != EXTRAS_MAX)) begin
                extras_d = extras_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ball_q   <= '0;
            over_q   <= '0;
            bio_q    <= '0;
            wkt_q    <= '0;
            extras_q <= '0;
        end else begin
            ball_q   <= ball_d;
            over_q   <= over_d;
            bio_q    <= bio_d;
            wkt_q    <= wkt_d;
            extras_q <= extras_d;
        end
    end

    assign ball         = ball_q;
    assign over_count   = over_q;
    assign ball_in_over = bio_q;
    assign wickets      = wkt_q;
    assign extras       = extras_q;

endmodule

// File: rtl/innings_tracker.sv
// Two-innings T20 delivery tracker: match FSM, per-team ball registers and innings termination.
// Optional free-hit handling is enabled by defining FREE_HIT_EN.
module innings_tracker
    import cricket_pkg::*;
#(
    parameter int OVERS          = 20,
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_WICKETS    = 10,
    parameter int BALL_W         = $clog2(OVERS * BALLS_PER_OVER + 1),
    parameter int OVER_W         = $clog2(OVERS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ev_valid,
    input  logic [1:0]        ev_code,
    output logic              team,
    output logic [BALL_W-1:0] ball_count,
    output logic [BALL_W-1:0] team_1_ball,
    output logic [BALL_W-1:0] team_2_ball,
    output logic [OVER_W-1:0] over_count,
    output logic [3:0]        ball_in_over,
    output logic [3:0]        wickets,
    output logic [7:0]        extras,
    output logic              innings_done,
    output logic              game_over,
    output logic              free_hit
);

    localparam logic [BALL_W-1:0] BALL_LAST = BALL_W'(OVERS * BALLS_PER_OVER - 1);
    localparam logic [3:0]        WKT_LAST  = 4'(MAX_WICKETS - 1);

    state_e            state_q, state_d;
    logic              innings_done_q, innings_done_d;
    logic [BALL_W-1:0] t1_ball_q, t1_ball_d;
    logic [BALL_W-1:0] t2_ball_q, t2_ball_d;
    logic [BALL_W-1:0] inn_ball;
    ev_code_e          code;
    logic              act, fh_now, clr;
    logic              inc_ball, inc_wkt, inc_extra, limit;

    assign code = ev_code_e'(ev_code);
    assign act  = ev_valid && ((state_q == S_INN1) || (state_q == S_INN2));

`ifdef FREE_HIT_EN
    logic free_hit_q, free_hit_d;

    always_comb begin
        free_hit_d = free_hit_q;
        if (clr) begin
            free_hit_d = 1'b0;
        end else if (act) begin
            case (code)
                EV_NOBALL: free_hit_d = 1'b1;
                EV_LEGAL:  free_hit_d = 1'b0;
                EV_WICKET: free_hit_d = 1'b0;
                default:   free_hit_d = free_hit_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) free_hit_q <= 1'b0;
        else     free_hit_q <= free_hit_d;
    end

    assign fh_now   = free_hit_q;
    assign free_hit = free_hit_q;
`else
    assign fh_now   = 1'b0;
    assign free_hit = 1'b0;
`endif

    // A wicket on a free hit still counts as a legal ball, just without the dismissal.
    assign inc_ball  = act && ((code == EV_LEGAL) || (code == EV_WICKET));
    assign inc_wkt   = act && (code == EV_WICKET) && !fh_now;
    assign inc_extra = act && ((code == EV_WIDE) || (code == EV_NOBALL));
    assign limit     = (inc_ball && (inn_ball == BALL_LAST)) ||
                       (inc_wkt && (wickets == WKT_LAST));

    always_comb begin
        state_d        = state_q;
        innings_done_d = 1'b0;
        clr            = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_INN1;
            S_INN1: begin
                if (limit) begin
                    state_d        = S_BREAK;
                    innings_done_d = 1'b1;
                end
            end
            S_BREAK: begin
                if (start) begin
                    state_d = S_INN2;
                    clr     = 1'b1;
                end
            end
            S_INN2: begin
                if (limit) begin
                    state_d        = S_DONE;
                    innings_done_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        t1_ball_d = t1_ball_q;
        t2_ball_d = t2_ball_q;
        if (inc_ball && (state_q == S_INN1)) t1_ball_d = t1_ball_q + BALL_W'(1);
        if (inc_ball && (state_q == S_INN2)) t2_ball_d = t2_ball_q + BALL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            innings_done_q <= 1'b0;
            t1_ball_q      <= '0;
            t2_ball_q      <= '0;
        end else begin
            state_q        <= state_d;
            innings_done_q <= innings_done_d;
            t1_ball_q      <= t1_ball_d;
            t2_ball_q      <= t2_ball_d;
        end
    end

    innings_counter #(
        .OVERS          (OVERS),
        .BALLS_PER_OVER (BALLS_PER_OVER),
        .BALL_W         (BALL_W),
        .OVER_W         (OVER_W)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .inc_ball     (inc_ball),
        .inc_wkt      (inc_wkt),
        .inc_extra    (inc_extra),
        .ball         (inn_ball),
        .over_count   (over_count),
        .ball_in_over (ball_in_over),
        .wickets      (wickets),
        .extras       (extras)
    );

    assign team         = (state_q == S_BREAK) || (state_q == S_INN2) || (state_q == S_DONE);
    assign team_1_ball  = t1_ball_q;
    assign team_2_ball  = t2_ball_q;
    assign ball_count   = team ? t2_ball_q : t1_ball_q;
    assign innings_done = innings_done_q;
    assign game_over    = (state_q == S_DONE);

endmodule

// File: tb/tb_innings_tracker.sv
// Directed bench for innings_tracker: default 20-over build plus a 2-over / 4-ball / 3-wicket build.
`timescale 1ns/1ps
module tb_innings_tracker;

  localparam logic [1:0] L = 2'd0;
  localparam logic [1:0] W = 2'd1;
  localparam logic [1:0] N = 2'd2;
  localparam logic [1:0] K = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_code = 2'd0;
  logic       s_start = 1'b0;
  logic       s_ev_valid = 1'b0;
  logic [1:0] s_ev_code = 2'd0;

  logic       team, innings_done, game_over, free_hit;
  logic [6:0] ball_count, team_1_ball, team_2_ball;
  logic [4:0] over_count;
  logic [3:0] ball_in_over, wickets;
  logic [7:0] extras;

  logic       s_team, s_innings_done, s_game_over, s_free_hit;
  logic [3:0] s_ball_count, s_team_1_ball, s_team_2_ball;
  logic [1:0] s_over_count;
  logic [3:0] s_ball_in_over, s_wickets;
  logic [7:0] s_extras;

  int total = 0;
  int bad   = 0;

  innings_tracker u_dut (
    .clk(clk), .rst(rst), .start(start), .ev_valid(ev_valid), .ev_code(ev_code),
    .team(team), .ball_count(ball_count), .team_1_ball(team_1_ball),
    .team_2_ball(team_2_ball), .over_count(over_count), .ball_in_over(ball_in_over),
    .wickets(wickets), .extras(extras), .innings_done(innings_done),
    .game_over(game_over), .free_hit(free_hit)
  );

  innings_tracker #(.OVERS(2), .BALLS_PER_OVER(4), .MAX_WICKETS(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .ev_valid(s_ev_valid), .ev_code(s_ev_code),
    .team(s_team), .ball_count(s_ball_count), .team_1_ball(s_team_1_ball),
    .team_2_ball(s_team_2_ball), .over_count(s_over_count), .ball_in_over(s_ball_in_over),
    .wickets(s_wickets), .extras(s_extras), .innings_done(s_innings_done),
    .game_over(s_game_over), .free_hit(s_free_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [1:0] c);
    ev_valid = 1'b1;
    ev_code  = c;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic sev(input logic [1:0] c);
    s_ev_valid = 1'b1;
    s_ev_code  = c;
    tick();
    s_ev_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_team", team, 1'b0);
    chk("rst_ball", ball_count, 0);
    chk("rst_over", over_count, 0);
    chk("rst_extras", extras, 0);
    chk("rst_done", innings_done, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    chk("rst_free_hit", free_hit, 1'b0);

    ev(L);
    chk("idle_ev_ignored", ball_count, 0);

    pulse_start();
    for (int i = 0; i < 7; i++) ev(L);
    chk("seven_over", over_count, 1);
    chk("seven_bio", ball_in_over, 1);
    chk("seven_t1", team_1_ball, 7);
    chk("seven_team", team, 1'b0);

    pulse_start();
    chk("start_in_inn1_team", team, 1'b0);
    chk("start_in_inn1_ball", ball_count, 7);

    ev(W);
    ev(N);
`ifdef FREE_HIT_EN
    chk("noball_sets_fh", free_hit, 1'b1);
`else
    chk("noball_fh_off", free_hit, 1'b0);
`endif
    ev(L);
    chk("extras_two", extras, 2);
    chk("extras_ball", ball_count, 8);
    chk("legal_clears_fh", free_hit, 1'b0);

    ev(N);
    ev(K);
    chk("wkt_after_nb_ball", ball_count, 9);
    chk("wkt_after_nb_bio", ball_in_over, 3);
    chk("wkt_after_nb_fh", free_hit, 1'b0);
`ifdef FREE_HIT_EN
    chk("free_hit_wickets", wickets, 0);
`else
    chk("dismissal_wickets", wickets, 1);
`endif

    for (int i = 0; i < 110; i++) ev(L);
    chk("b119_ball", ball_count, 119);
    chk("b119_over", over_count, 19);
    chk("b119_bio", ball_in_over, 5);
    chk("b119_done", innings_done, 1'b0);
    ev(L);
    chk("b120_done", innings_done, 1'b1);
    chk("b120_team", team, 1'b1);
    chk("b120_t1", team_1_ball, 120);
    chk("b120_ball_count", ball_count, 0);
    chk("b120_game_over", game_over, 1'b0);
    tick();
    chk("done_one_cycle", innings_done, 1'b0);
    ev(L);
    chk("break_ev_t1", team_1_ball, 120);
    chk("break_ev_t2", team_2_ball, 0);

    pulse_start();
    chk("inn2_over_clr", over_count, 0);
    chk("inn2_bio_clr", ball_in_over, 0);
    chk("inn2_wkt_clr", wickets, 0);
    chk("inn2_extras_clr", extras, 0);
    chk("inn2_team", team, 1'b1);
    for (int i = 0; i < 3; i++) ev(L);
    for (int i = 0; i < 9; i++) ev(K);
    chk("w9_wickets", wickets, 9);
    chk("w9_game_over", game_over, 1'b0);
    ev(K);
    chk("w10_wickets", wickets, 10);
    chk("w10_t2", team_2_ball, 13);
    chk("w10_game_over", game_over, 1'b1);
    chk("w10_done", innings_done, 1'b1);
    chk("w10_t1_kept", team_1_ball, 120);
    ev(L);
    chk("done_ev_ignored", team_2_ball, 13);
    chk("done_pulse_drop", innings_done, 1'b0);
    pulse_start();
    chk("done_holds", game_over, 1'b1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 256; i++) ev(W);
    chk("extras_saturate", extras, 255);
    for (int i = 0; i < 10; i++) ev(K);
    chk("inn1_wkt_end_done", innings_done, 1'b1);
    chk("inn1_wkt_end_team", team, 1'b1);
    pulse_start();
    ev(L);
    ev(L);
    ev(W);
    chk("inn2_pre_rst_ball", ball_count, 2);
    chk("inn2_pre_rst_extras", extras, 1);
    rst      = 1'b1;
    start    = 1'b1;
    ev_valid = 1'b1;
    ev_code  = L;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    ev_valid = 1'b0;
    chk("mid_rst_team", team, 1'b0);
    chk("mid_rst_ball", ball_count, 0);
    chk("mid_rst_t1", team_1_ball, 0);
    chk("mid_rst_t2", team_2_ball, 0);
    chk("mid_rst_extras", extras, 0);
    chk("mid_rst_game_over", game_over, 1'b0);
    chk("mid_rst_done", innings_done, 1'b0);
    ev(L);
    chk("mid_rst_idle", ball_count, 0);

    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int i = 0; i < 7; i++) sev(L);
    chk("small_b7_over", s_over_count, 1);
    chk("small_b7_bio", s_ball_in_over, 3);
    chk("small_b7_done", s_innings_done, 1'b0);
    sev(L);
    chk("small_b8_done", s_innings_done, 1'b1);
    chk("small_b8_team", s_team, 1'b1);
    chk("small_b8_t1", s_team_1_ball, 8);
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    sev(K);
    sev(L);
    sev(K);
    chk("small_w2_wickets", s_wickets, 2);
    chk("small_w2_game_over", s_game_over, 1'b0);
    sev(K);
    chk("small_w3_wickets", s_wickets, 3);
    chk("small_w3_game_over", s_game_over, 1'b1);
    chk("small_w3_ball", s_ball_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/innings_tracker.md
# innings_tracker

Parametrised per-innings delivery tracker for the T20 scoring datapath. Consumes one delivery event per valid strobe from the event generator, counts legal balls, overs, balls-in-over, wickets and extras for each team, and sequences the match through two innings with a break. It replaces the fixed 120-ball counter. Limits such as overs, balls per over and wicket limit are parameters. Innings termination is decided internally rather than by the caller.

## Interface
- OVERS, 20, overs per innings (1..50)
- BALLS_PER_OVER, 6, legal balls per over (1..15)
- MAX_WICKETS, 10, wickets that end an innings (1..15)
- BALL_W, $clog2(OVERS*BALLS_PER_OVER+1), derived ball counter width
- OVER_W, $clog2(OVERS+1), derived over counter width
- clk  in  1  single clock for the block
- rst  in  1  synchronous, active-high reset
- start  in  1  begins innings 1 from IDLE, or innings 2 from BREAK
- ev_valid  in  1  one delivery event this cycle
- ev_code  in  2  0=LEGAL, 1=WIDE, 2=NOBALL, 3=WICKET (legal ball plus dismissal)
- team  out  1  0 while team 1 bats (IDLE/INN1), 1 from BREAK onward
- ball_count  out  BALL_W  legal balls of the batting team
- team_1_ball, team_2_ball  out  BALL_W  legal balls per team (LED drive)
- over_count  out  OVER_W  completed overs of the batting team
- ball_in_over  out  4  legal balls in the current over (0..BALLS_PER_OVER-1)
- wickets  out  4  wickets of the batting team
- extras  out  8  wides plus no-balls of the batting team, saturating at 255
- innings_done  out  1  one-cycle pulse when an innings ends
- game_over  out  1  high in DONE
- free_hit  out  1  next delivery is a free hit (0 when the feature is compiled out)

## Operation
- States: IDLE -> INN1 on start; INN1 -> BREAK on limit; BREAK -> INN2 on start; INN2 -> DONE on limit. DONE holds until rst.
- Limit is reached when, after the update, legal balls == OVERS*BALLS_PER_OVER or wickets == MAX_WICKETS. If both occur on the same event, it is a single termination.
- LEGAL: ball+1 and ball_in_over+1. When ball_in_over reaches BALLS_PER_OVER, it wraps to 0 and over_count increments.
- WICKET: same as LEGAL, plus wickets+1.
- WIDE and NOBALL: no ball change; extras+1, saturating.
- Events are ignored outside INN1/INN2, including the event after the terminating event.
- start is ignored outside IDLE/BREAK.
- Entering INN2 clears over_count, ball_in_over, wickets, extras and free_hit. team_1_ball is retained.
- ball_count is combinational: it is team_1_ball when team=0, otherwise team_2_ball.

## Timing
- All counters and state are registered and update on the clk edge where ev_valid=1. Counter latency is 1 cycle.
- innings_done is asserted in the cycle the state enters BREAK or DONE, for exactly 1 cycle.
- rst, at any point including mid-innings, forces the following in the next cycle:
  - state IDLE, team=0
  - all counters 0
  - innings_done=0, game_over=0, free_hit=0
- rst has priority over start and ev_valid.
- Back-to-back events on consecutive cycles are each applied.

## Configuration
- FREE_HIT_EN defined:
  - NOBALL sets free_hit.
  - On a free hit, WICKET counts as LEGAL without a dismissal and clears free_hit.
  - LEGAL clears free_hit.
  - WIDE and NOBALL keep free_hit set.
- FREE_HIT_EN undefined: free_hit is tied to 0 and WICKET always dismisses.

## Structure
- Shared package cricket_pkg holds:
  - the ev_code enum (EV_LEGAL, EV_WIDE, EV_NOBALL, EV_WICKET)
  - the state enum (S_IDLE, S_INN1, S_BREAK, S_INN2, S_DONE)
  - the EXTRAS_MAX constant
- Sub-module innings_counter holds the ball, over, ball-in-over, wickets and extras registers with clear/enable. It is instantiated once and cleared on BREAK->INN2.
- Per-team ball registers and the FSM live in the top level.

## Test plan
- rst, start, 7 LEGAL events -> over_count=1, ball_in_over=1, team_1_ball=7, team=0.
- 120 LEGAL events with defaults -> innings_done pulse on the 120th, state BREAK, team=1, and a further LEGAL leaves team_1_ball=120.
- start, 3 LEGAL then 10 WICKET events -> wickets=10, team_2_ball=13, game_over=1, team_1_ball unchanged.
- In INN1, WIDE, NOBALL, LEGAL -> extras=2, ball_count=1. With FREE_HIT_EN, NOBALL then WICKET -> wickets=0, ball_count+1, free_hit=0.
- rst asserted mid-INN2 with ev_valid=1 -> next cycle all outputs 0, state IDLE.
- Parameters OVERS=2, BALLS_PER_OVER=4, MAX_WICKETS=3 -> innings ends after 8 legal balls, or after the 3rd wicket if that comes earlier.
